// File: rtl/rom_rr_arbiter_pkg.sv
// rtl/rom_rr_arbiter_pkg.sv - shared defaults and tag types for the ROM round-robin arbiter
package rom_arb_pkg;

    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ROM_LAT = 1;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // Pointer starts as "requester 1 granted last" so requester 0 wins the first tie.
    localparam req_id_t RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/rom_rr_arbiter_if.sv
// rtl/rom_rr_arbiter_if.sv - one requester's read request/response port
interface rom_rr_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rvalid, input rdata);
    modport slave  (input req, input addr, output ack, output rvalid, output rdata);
endinterface

// File: rtl/rom_rr_arbiter_rr_arb2.sv
// rtl/rom_rr_arbiter_rr_arb2.sv - 2-way round-robin picker owning the last-grant pointer
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       grant,
    output logic [1:0] win
);
    req_id_t last;

    always_comb begin
        win = 2'b00;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (last == 1'b1) ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= RR_RESET_LAST;
        end else if (grant) begin
            last <= win[1];
        end
    end
endmodule

// File: rtl/rom_rr_arbiter.sv
// rtl/rom_rr_arbiter.sv - shares one registered ROM read port between two requesters
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = DEF_ROM_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arb_en,
    rom_rr_arbiter_if.slave     cli0,
    rom_rr_arbiter_if.slave     cli1,
    output logic                rom_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data
);
    logic [1:0] elig;
    logic [1:0] win;
    logic       grant;
    tag_t       stage [0:ROM_LAT];
    tag_t       out_tag;

    // A requester just acked cannot win again, so one holding req alternates with the other.
    assign elig[0] = cli0.req & ~cli0.ack & arb_en;
    assign elig[1] = cli1.req & ~cli1.ack & arb_en;
    assign grant   = |win;
    assign out_tag = stage[ROM_LAT];

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .elig  (elig),
        .grant (grant),
        .win   (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            cli0.ack    <= 1'b0;
            cli1.ack    <= 1'b0;
            cli0.rvalid <= 1'b0;
            cli1.rvalid <= 1'b0;
            cli0.rdata  <= '0;
            cli1.rdata  <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            rom_en   <= grant;
            cli0.ack <= win[0];
            cli1.ack <= win[1];
            if (win[0]) begin
                rom_addr <= cli0.addr;
            end else if (win[1]) begin
                rom_addr <= cli1.addr;
            end

            stage[0].valid <= grant;
            stage[0].id    <= win[1];
            for (int i = 1; i <= ROM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end

            // rom_data is only trusted when a live tag reaches the output stage.
            cli0.rvalid <= out_tag.valid & (out_tag.id == 1'b0);
            cli1.rvalid <= out_tag.valid & (out_tag.id == 1'b1);
            if (out_tag.valid && out_tag.id == 1'b0) begin
                cli0.rdata <= rom_data;
            end
            if (out_tag.valid && out_tag.id == 1'b1) begin
                cli1.rdata <= rom_data;
            end
        end
    end
endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb/tb_rom_rr_arbiter.sv - directed table-driven bench for rom_rr_arbiter
module tb_rom_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arb_en = 1'b0;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data;

    rom_rr_arbiter_if #(.ADDR_W(3), .DATA_W(16)) c0 ();
    rom_rr_arbiter_if #(.ADDR_W(3), .DATA_W(16)) c1 ();

    rom_rr_arbiter #(.ADDR_W(3), .DATA_W(16), .ROM_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (arb_en),
        .cli0     (c0),
        .cli1     (c1),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [8];
    logic [15:0] rom_q;
    logic        rom_pend = 1'b0;
    logic        force_x = 1'b0;

    always @(posedge clk) begin
        if (rom_en) rom_q <= mem[rom_addr];
        rom_pend <= rom_en;
    end
    assign rom_data = (rom_pend && !force_x) ? rom_q : 16'hxxxx;

    typedef struct {
        logic        rst_before;
        logic        en;
        logic        req0;
        logic [2:0]  addr0;
        logic        req1;
        logic [2:0]  addr1;
        logic        ack0;
        logic        ack1;
        logic        rom_en;
        logic        rvalid0;
        logic        rvalid1;
        logic [15:0] rdata0;
        logic [15:0] rdata1;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    int rv0_cnt = 0;
    int rv1_cnt = 0;

    function automatic vec_t mk(logic rb, logic en, logic r0, logic [2:0] a0, logic r1, logic [2:0] a1,
                                logic k0, logic k1, logic re, logic v0, logic v1,
                                logic [15:0] d0, logic [15:0] d1);
        vec_t v;
        v.rst_before = rb; v.en = en;
        v.req0 = r0; v.addr0 = a0; v.req1 = r1; v.addr1 = a1;
        v.ack0 = k0; v.ack1 = k1; v.rom_en = re; v.rvalid0 = v0; v.rvalid1 = v1;
        v.rdata0 = d0; v.rdata1 = d1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        c0.req = 1'b0; c0.addr = '0;
        c1.req = 1'b0; c1.addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        mem[0] = 16'hAAAA; mem[1] = 16'hABCD; mem[2] = 16'h1111; mem[3] = 16'h2222;
        mem[4] = 16'h3333; mem[5] = 16'h4444; mem[6] = 16'h7B4E; mem[7] = 16'h9A2B;
        c0.req = 1'b0; c0.addr = '0;
        c1.req = 1'b0; c1.addr = '0;

        #2;
        chk("reset_rom_en", {31'd0, rom_en}, 32'd0);
        chk("reset_rom_addr", {29'd0, rom_addr}, 32'd0);
        chk("reset_ack", {30'd0, c0.ack, c1.ack}, 32'd0);
        chk("reset_rvalid", {30'd0, c0.rvalid, c1.rvalid}, 32'd0);
        chk("reset_rdata", {c0.rdata, c1.rdata}, 32'd0);

        // single read
        vecs.push_back(mk(1, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, 16'hABCD, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 16'hABCD, 16'h0000));
        // tie
        vecs.push_back(mk(1, 1, 1, 6, 1, 7,  1, 0, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 6, 1, 7,  0, 1, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 6, 0, 7,  0, 0, 0, 1, 0, 16'h7B4E, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 6, 0, 7,  0, 0, 0, 0, 1, 16'h7B4E, 16'h9A2B));
        vecs.push_back(mk(0, 1, 0, 6, 0, 7,  0, 0, 0, 0, 0, 16'h7B4E, 16'h9A2B));
        // saturation: both held 10 cycles
        for (int k = 0; k < 13; k++) begin
            vecs.push_back(mk(k == 0, 1, k < 10, 0, k < 10, 1,
                              (k < 10) && (k % 2 == 0), (k < 10) && (k % 2 == 1), k < 10,
                              (k >= 2) && (k <= 10) && (k % 2 == 0),
                              (k >= 3) && (k <= 11) && (k % 2 == 1),
                              (k >= 2) ? 16'hAAAA : 16'h0000,
                              (k >= 3) ? 16'hABCD : 16'h0000));
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            arb_en = vecs[i].en;
            c0.req = vecs[i].req0; c0.addr = vecs[i].addr0;
            c1.req = vecs[i].req1; c1.addr = vecs[i].addr1;
            step();
            chk($sformatf("v%0d_ack0", i), {31'd0, c0.ack}, {31'd0, vecs[i].ack0});
            chk($sformatf("v%0d_ack1", i), {31'd0, c1.ack}, {31'd0, vecs[i].ack1});
            chk($sformatf("v%0d_rom_en", i), {31'd0, rom_en}, {31'd0, vecs[i].rom_en});
            chk($sformatf("v%0d_rvalid0", i), {31'd0, c0.rvalid}, {31'd0, vecs[i].rvalid0});
            chk($sformatf("v%0d_rvalid1", i), {31'd0, c1.rvalid}, {31'd0, vecs[i].rvalid1});
            chk($sformatf("v%0d_rdata0", i), {16'd0, c0.rdata}, {16'd0, vecs[i].rdata0});
            chk($sformatf("v%0d_rdata1", i), {16'd0, c1.rdata}, {16'd0, vecs[i].rdata1});
            if (c0.rvalid === 1'b1) rv0_cnt++;
            if (c1.rvalid === 1'b1) rv1_cnt++;
        end
        chk("table_rvalid0_count", rv0_cnt, 32'd7);
        chk("table_rvalid1_count", rv1_cnt, 32'd6);

        // gating: arb_en drops with a read in flight and req0 pending
        do_reset();
        arb_en = 1'b1; c1.req = 1'b1; c1.addr = 3'd7;
        step();
        chk("gate_ack1", {31'd0, c1.ack}, 32'd1);
        c1.req = 1'b0; arb_en = 1'b0; c0.req = 1'b1; c0.addr = 3'd6;
        step();
        chk("gate_no_ack0_a", {31'd0, c0.ack}, 32'd0);
        chk("gate_rom_en_off", {31'd0, rom_en}, 32'd0);
        step();
        chk("gate_rvalid1", {31'd0, c1.rvalid}, 32'd1);
        chk("gate_rdata1", {16'd0, c1.rdata}, 32'h9A2B);
        chk("gate_no_ack0_b", {31'd0, c0.ack}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("gate_hold_ack0", {31'd0, c0.ack}, 32'd0);
            chk("gate_hold_rom_en", {31'd0, rom_en}, 32'd0);
        end
        arb_en = 1'b1;
        step();
        chk("gate_resume_ack0", {31'd0, c0.ack}, 32'd1);
        chk("gate_resume_addr", {29'd0, rom_addr}, 32'd6);
        c0.req = 1'b0;
        step();
        step();
        chk("gate_rvalid0", {31'd0, c0.rvalid}, 32'd1);
        chk("gate_rdata0", {16'd0, c0.rdata}, 32'h7B4E);

        // reset with a read in flight
        do_reset();
        c0.req = 1'b1; c0.addr = 3'd1;
        step();
        chk("rst_pre_ack0", {31'd0, c0.ack}, 32'd1);
        c0.req = 1'b0;
        step();
        chk("rst_pre_addr", {29'd0, rom_addr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_addr", {29'd0, rom_addr}, 32'd0);
        chk("rst_async_en_ack", {29'd0, rom_en, c0.ack, c1.ack}, 32'd0);
        chk("rst_async_rvalid", {30'd0, c0.rvalid, c1.rvalid}, 32'd0);
        chk("rst_async_rdata", {c0.rdata, c1.rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_no_rvalid", {30'd0, c0.rvalid, c1.rvalid}, 32'd0);
        end
        c0.req = 1'b1; c0.addr = 3'd6; c1.req = 1'b1; c1.addr = 3'd7;
        step();
        chk("rst_tie_first", {30'd0, c0.ack, c1.ack}, 32'b10);
        c0.req = 1'b0;
        step();
        chk("rst_tie_second", {30'd0, c0.ack, c1.ack}, 32'b01);
        c1.req = 1'b0;
        step();
        chk("rst_tie_rdata0", {15'd0, c0.rvalid, c0.rdata}, 32'h17B4E);
        step();
        chk("rst_tie_rdata1", {15'd0, c1.rvalid, c1.rdata}, 32'h19A2B);

        // idle bus with garbage on rom_data
        force_x = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("idle_rvalid", {30'd0, c0.rvalid, c1.rvalid}, 32'd0);
            chk("idle_rdata", {c0.rdata, c1.rdata}, 32'h7B4E9A2B);
            chk("idle_rom_en", {31'd0, rom_en}, 32'd0);
        end
        force_x = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
